// File: rtl/clicklatch_multi.sv
`default_nettype none
// ============================================================================
// Module   : clicklatch_multi
// Purpose  : Multichannel click edge latch. Each channel synchronises an
//            asynchronous detector click and turns every low-to-high
//            transition into a one-clock 'data' pulse. A programmable dead
//            time (hold-off) follows every accepted edge; edges arriving
//            inside it are reported on 'blocked' instead. Same-cycle
//            multi-channel events are flagged on 'multi'.
// Ports    : clock     - system clock, rising edge
//            reset     - synchronous, active-high reset
//            click     - [CHANNELS] asynchronous detector pulses
//            enable    - [CHANNELS] per-channel enable
//            deadtime  - [DEADTIME_W] hold-off length in clocks, captured
//                        when an edge is accepted
//            data      - [CHANNELS] one-clock pulse per accepted edge
//            blocked   - [CHANNELS] one-clock pulse per rejected edge
//            any_click - OR of data
//            multi     - two or more data bits high in the same cycle
// Revision : 1.0 - initial release
// ============================================================================
module clicklatch_multi #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEADTIME_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   click,
    input  logic [CHANNELS-1:0]   enable,
    input  logic [DEADTIME_W-1:0] deadtime,
    output logic [CHANNELS-1:0]   data,
    output logic [CHANNELS-1:0]   blocked,
    output logic                  any_click,
    output logic                  multi
);

    localparam logic [DEADTIME_W-1:0] c_dt_one   = {{(DEADTIME_W-1){1'b0}}, 1'b1};
    localparam logic [CHANNELS-1:0]   c_data_one = {{(CHANNELS-1){1'b0}}, 1'b1};

    // r_sync[i][0] is the first capture flop; the MSB is the synchronised
    // sample s[i].
    logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
    logic [DEADTIME_W-1:0]  r_dt   [CHANNELS];
    logic [CHANNELS-1:0]    r_prev;
    logic [CHANNELS-1:0]    r_data;
    logic [CHANNELS-1:0]    r_blocked;
    logic [CHANNELS-1:0]    w_edge;

    always_comb begin
        w_edge = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_edge[i] = r_sync[i][SYNC_STAGES-1] & ~r_prev[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // Synchroniser and previous sample reset high so that a click
            // held through reset is not seen as a fresh rising edge.
            for (int i = 0; i < CHANNELS; i++) begin
                r_sync[i] <= '1;
                r_dt[i]   <= '0;
            end
            r_prev    <= '1;
            r_data    <= '0;
            r_blocked <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sync[i]    <= {r_sync[i][SYNC_STAGES-2:0], click[i]};
                r_prev[i]    <= r_sync[i][SYNC_STAGES-1];
                r_data[i]    <= 1'b0;
                r_blocked[i] <= 1'b0;
                if (w_edge[i] && enable[i] && (r_dt[i] == '0)) begin
                    r_data[i] <= 1'b1;
                    r_dt[i]   <= deadtime;
                end else begin
                    // A rejected edge does not restart the hold-off; the
                    // counter keeps running down either way.
                    if (w_edge[i] && enable[i]) begin
                        r_blocked[i] <= 1'b1;
                    end
                    if (r_dt[i] != '0) begin
                        r_dt[i] <= r_dt[i] - c_dt_one;
                    end
                end
            end
        end
    end

    assign data      = r_data;
    assign blocked   = r_blocked;
    assign any_click = |r_data;
    // Clearing the lowest set bit leaves something only if two or more
    // bits were set.
    assign multi     = (r_data & (r_data - c_data_one)) != '0;

endmodule
`default_nettype wire
